pipo_write_arbiter: RTL

- Round-robin arbiter and sequencer that shares one parallel-in/parallel-out data register among NREQ requesters.
- The shared register is internal to this block.
- Each requester presents a request and a data word. The block grants one requester at a time, loads that requester's word into the shared register in a single write cycle, acknowledges it, and holds the grant for a fixed settle window.
- Sits between multiple producer blocks and the downstream consumer of the shared register output q.

---
 rtl/pipo_write_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipo_write_arbiter.sv
// pipo_write_arbiter
//
// Round-robin arbiter and sequencer that shares one internal parallel-in /
// parallel-out data register among NREQ requesters.
//
// Each transaction is one grant cycle (WRITE), then HOLD_CYC settle cycles (HOLD).
// The granted requester's word is loaded into q at the WRITE->HOLD edge and ack
// pulses for one cycle. One IDLE cycle always separates back-to-back grants.
//
// Ports:
//   clk    in   1            system clock, rising edge
//   reset  in   1            synchronous, active-low reset
//   req    in   NREQ         level-sensitive request per requester
//   wdata  in   NREQ*WIDTH   data of requester i at [i*WIDTH +: WIDTH]
//   gnt    out  NREQ         one-hot grant, zero when idle
//   ack    out  NREQ         one-cycle pulse to the owner once its word is in q
//   q      out  WIDTH        shared register contents
//   owner  out  OW           index of the current or last granted requester
//   busy   out  1            high while a transaction is in progress
module pipo_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 4,
  parameter int HOLD_CYC = 2,
  localparam int OW      = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        q,
  output logic [OW-1:0]           owner,
  output logic                    busy
);

  // Illegal configurations stop elaboration.
  generate
    if (HOLD_CYC < 1) begin : g_bad_hold
      $error("pipo_write_arbiter: HOLD_CYC must be >= 1");
    end
    if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
      $error("pipo_write_arbiter: NREQ must be in 2..8");
    end
  endgenerate

  // Hold counter must be at least one bit wide even when HOLD_CYC is 1.
  localparam int            HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [OW-1:0] LAST_REQ  = OW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [OW-1:0]        ptr_reg, ptr_next;
  logic [HW-1:0]        hcnt_reg, hcnt_next;
  logic [NREQ-1:0]      gnt_reg, gnt_next;
  logic [NREQ-1:0]      ack_reg, ack_next;
  logic [WIDTH-1:0]     q_reg, q_next;
  logic [OW-1:0]        owner_reg, owner_next;
  logic                 busy_reg, busy_next;

  // Per-requester view of the flat data bus.
  logic [WIDTH-1:0]     wslice [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign wslice[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Requester index at a given distance from the round-robin pointer.
  function automatic logic [OW-1:0] rr_index(input logic [OW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return OW'(sum);
  endfunction

  // Round-robin pick: scanning from the far end down means the request
  // closest to ptr is the last one written, so it wins.
  logic                 found;
  logic [OW-1:0]        sel;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[rr_index(ptr_reg, off)]) begin
        found = 1'b1;
        sel   = rr_index(ptr_reg, off);
      end
    end
  end

  // Next-state and output logic. Every output is registered, so the values
  // computed here appear on the ports one edge later.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    hcnt_next  = hcnt_reg;
    gnt_next   = gnt_reg;
    ack_next   = '0;
    q_next     = q_reg;
    owner_next = owner_reg;
    busy_next  = busy_reg;

    case (state_reg)
      IDLE: begin
        gnt_next  = '0;
        busy_next = 1'b0;
        if (found) begin
          state_next    = WRITE;
          gnt_next[sel] = 1'b1;
          owner_next    = sel;
          busy_next     = 1'b1;
        end
      end

      WRITE: begin
        // The word is taken from the bus as it stands at this edge.
        q_next              = wslice[owner_reg];
        ack_next[owner_reg] = 1'b1;
        hcnt_next           = '0;
        state_next          = HOLD;
      end

      HOLD: begin
        if (hcnt_reg == HOLD_LAST) begin
          gnt_next   = '0;
          busy_next  = 1'b0;
          hcnt_next  = '0;
          ptr_next   = (owner_reg == LAST_REQ) ? '0 : owner_reg + OW'(1);
          state_next = IDLE;
        end else begin
          hcnt_next = hcnt_reg + HW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      hcnt_reg  <= '0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      q_reg     <= '0;
      owner_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      hcnt_reg  <= hcnt_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
      q_reg     <= q_next;
      owner_reg <= owner_next;
      busy_reg  <= busy_next;
    end
  end

  assign gnt   = gnt_reg;
  assign ack   = ack_reg;
  assign q     = q_reg;
  assign owner = owner_reg;
  assign busy  = busy_reg;

endmodule
